result_logger: RTL and testbench
================================

// Module: result_logger
// PURPOSE
//  Capture buffer directly downstream of adder_mult. Records successive o_data results
//  (sum or product) into a DEPTH-entry register-file log on each valid strobe.
//  Log is armed by a run pulse and stops when full. A registered random-access read
//  port then drains the log to the host/UART side of the FIR log-memory design.
// PARAMETERS
//  NB_DATA  16  width of logged result (matches adder_mult NB_DATA_OUT)
//  NB_ADDR  5   log address width; DEPTH = 2**NB_ADDR = 32 entries
// PORTS
//  i_clock     in   1          system clock, rising edge
//  i_reset     in   1          asynchronous, active-low reset
//  i_run       in   1          1-cycle arm pulse: clears log, starts capture
//  i_valid     in   1          i_data qualifies this cycle
//  i_data      in   NB_DATA    result word from adder_mult o_data
//  i_rd_req    in   1          read request, one word per cycle
//  i_rd_addr   in   NB_ADDR    read address, 0 = oldest sample
//  o_rd_data   out  NB_DATA    read data, registered
//  o_rd_valid  out  1          o_rd_data valid this cycle
//  o_busy      out  1          1 while in LOG state
//  o_full      out  1          DEPTH samples captured
//  o_count     out  NB_ADDR+1  samples stored, 0..DEPTH
// BEHAVIOUR
//  Reset (i_reset=0, async): state=IDLE, wr_ptr=0, o_count=0, o_busy=0, o_full=0,
//   o_rd_valid=0, o_rd_data=0. Storage array is not reset.
//  FSM states:
//   IDLE: i_run -> LOG; on that edge count=0, wr_ptr=0, o_full=0.
//   LOG:  o_busy=1. Each i_valid cycle writes mem[wr_ptr]=i_data; wr_ptr++ and count++.
//         When the write makes count==DEPTH -> DONE the next cycle; o_full=1, o_busy=0.
//   DONE: holds data. i_run -> LOG with clear, same as in IDLE.
//  An i_valid in the same cycle as the accepting i_run is NOT written.
//   Capture begins on the following cycle.
//  i_run while in LOG: ignored (see CONFIGURATION).
//  Read: i_rd_req in IDLE/DONE -> o_rd_valid=1 and o_rd_data=mem[i_rd_addr] next cycle.
//   Latency is 1 cycle; back-to-back requests give one word per cycle.
//   i_rd_addr >= o_count returns o_rd_data=0 with o_rd_valid=1.
//   i_rd_req while in LOG: ignored, o_rd_valid=0, o_rd_data holds its last value.
//   Read and i_run in the same cycle: the read completes with pre-clear data.
//  No arithmetic on data; i_data is stored bit-exact (signed fixed point is opaque).
//  o_count saturates at DEPTH; wr_ptr wraps modulo DEPTH.
//  Reset asserted mid-LOG aborts immediately to IDLE with count=0.
// CONFIGURATION
//  LOGGER_WRAP_EN defined: circular capture.
//   LOG never self-terminates; wr_ptr wraps, overwriting the oldest entry.
//   o_full=1 from the first wrap onward; o_count saturates at DEPTH.
//   i_run while in LOG -> DONE (stop).
//   Read address is relative to the oldest entry: physical = (wr_ptr + i_rd_addr) mod DEPTH
//    when o_full, else i_rd_addr.
//  LOGGER_WRAP_EN undefined: behaviour exactly as in BEHAVIOUR; i_run in LOG is ignored.
// TESTING
//  1 Reset: hold i_reset=0 for 3 clocks, release -> all outputs 0, o_busy=0;
//    read addr 0 -> o_rd_valid=1 and o_rd_data=0 one cycle later.
//  2 Fill: i_run pulse, then 32 valid words 0x0000..0x001F
//    -> o_full=1 and o_count=32 one cycle after the last word;
//    reading addr 0..31 back-to-back returns 0x0000..0x001F at 1/cycle.
//  3 Gapped valid: i_valid every 3rd cycle, 5 words 0xA001..0xA005, then idle
//    -> o_count=5, o_busy=1; reads ignored (o_rd_valid=0);
//    the 27 further words complete the fill.
//  4 Run+valid collision: i_run and i_valid(0xBEEF) in the same cycle,
//    then valid 0x1234 -> mem[0]=0x1234, o_count=1 after the fill completes.
//  5 Mid-run reset: assert i_reset after 10 words -> same cycle o_busy=0, o_count=0;
//    after re-arm and a fresh fill the old data is not visible.
//  6 LOGGER_WRAP_EN: 40 words 0..39 then i_run -> DONE, o_full=1;
//    read addr 0 -> 8, addr 31 -> 39.

Source files
------------

// File: rtl/result_logger.sv
// rtl/result_logger.sv - DEPTH-entry capture log for adder_mult results with registered read port
// Optional circular capture: define LOGGER_WRAP_EN.
module result_logger #(
  parameter int NB_DATA = 16,
  parameter int NB_ADDR = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_run,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_rd_req,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data,
  output logic               o_rd_valid,
  output logic               o_busy,
  output logic               o_full,
  output logic [NB_ADDR:0]   o_count
);

  localparam int DEPTH = 1 << NB_ADDR;
  localparam logic [NB_ADDR:0] LAST_C = {1'b0, {NB_ADDR{1'b1}}};
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOG  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [NB_ADDR:0]   count_q, count_d;
  logic               full_q, full_d;
  logic [NB_DATA-1:0] rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic [NB_DATA-1:0] mem_q [DEPTH];
  logic               wr_en;
  logic [NB_ADDR-1:0] rd_phys;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    full_d     = full_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_en      = 1'b0;
    rd_phys    = i_rd_addr;
`ifdef LOGGER_WRAP_EN
    // Once wrapped, the oldest entry sits at the write pointer.
    if (full_q) rd_phys = wr_ptr_q + i_rd_addr;
`endif
    // Read uses pre-clear count, so a read alongside i_run sees the old log.
    if (state_q != ST_LOG && i_rd_req) begin
      rd_valid_d = 1'b1;
      rd_data_d  = ({1'b0, i_rd_addr} < count_q) ? mem_q[rd_phys] : '0;
    end
    case (state_q)
      ST_LOG: begin
`ifdef LOGGER_WRAP_EN
        if (i_run) begin
          state_d = ST_DONE;
        end else if (i_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + NB_ADDR'(1);
          if (count_q != LAST_C + (NB_ADDR+1)'(1)) count_d = count_q + (NB_ADDR+1)'(1);
          if (count_q == LAST_C) full_d = 1'b1;
        end
`else
        if (i_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + NB_ADDR'(1);
          count_d  = count_q + (NB_ADDR+1)'(1);
          if (count_q == LAST_C) begin
            full_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
`endif
      end
      default: begin
        if (i_run) begin
          state_d  = ST_LOG;
          count_d  = '0;
          wr_ptr_d = '0;
          full_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_busy     = (state_q == ST_LOG);
  assign o_full     = full_q;
  assign o_count    = count_q;

endmodule

// File: tb/tb_result_logger.sv
// tb/tb_result_logger.sv - self-checking bench for result_logger against a queue-based log model
module tb_result_logger;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_run = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_data = '0;
  logic        i_rd_req = 1'b0;
  logic [4:0]  i_rd_addr = '0;
  logic [15:0] o_rd_data;
  logic        o_rd_valid;
  logic        o_busy;
  logic        o_full;
  logic [5:0]  o_count;

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] m_log[$];
  bit          m_logging = 0;
  bit          m_full = 0;
  bit          m_rv = 0;
  logic [15:0] m_rd = '0;

  always #5 clk = ~clk;

  result_logger #(.NB_DATA(16), .NB_ADDR(5)) dut (
    .i_clock   (clk),
    .i_reset   (i_reset),
    .i_run     (i_run),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .i_rd_req  (i_rd_req),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data),
    .o_rd_valid(o_rd_valid),
    .o_busy    (o_busy),
    .o_full    (o_full),
    .o_count   (o_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_log.delete();
    m_logging = 0;
    m_full = 0;
    m_rv = 0;
    m_rd = '0;
  endtask

  // Log modelled as an oldest-first list of captured words.
  task automatic model_edge(input bit run, input bit valid, input logic [15:0] data,
                            input bit rdreq, input logic [4:0] addr);
    if (!m_logging && rdreq) begin
      m_rv = 1;
      m_rd = (int'(addr) < m_log.size()) ? m_log[addr] : 16'h0;
    end else begin
      m_rv = 0;
    end
    if (!m_logging) begin
      if (run) begin
        m_log.delete();
        m_logging = 1;
        m_full = 0;
      end
    end else begin
`ifdef LOGGER_WRAP_EN
      if (run) begin
        m_logging = 0;
      end else if (valid) begin
        m_log.push_back(data);
        if (m_log.size() > 32) void'(m_log.pop_front());
        if (m_log.size() == 32) m_full = 1;
      end
`else
      if (valid) begin
        m_log.push_back(data);
        if (m_log.size() == 32) begin
          m_logging = 0;
          m_full = 1;
        end
      end
`endif
    end
  endtask

  task automatic check_all();
    chk("busy", 32'(o_busy), 32'(m_logging));
    chk("full", 32'(o_full), 32'(m_full));
    chk("count", 32'(o_count), 32'(m_log.size()));
    chk("rd_valid", 32'(o_rd_valid), 32'(m_rv));
    chk("rd_data", 32'(o_rd_data), 32'(m_rd));
  endtask

  task automatic cyc(input bit run, input bit valid, input logic [15:0] data,
                     input bit rdreq, input logic [4:0] addr);
    i_run = run;
    i_valid = valid;
    i_data = data;
    i_rd_req = rdreq;
    i_rd_addr = addr;
    @(posedge clk);
    #1;
    model_edge(run, valid, data, rdreq, addr);
    i_run = 0;
    i_valid = 0;
    i_rd_req = 0;
    check_all();
  endtask

  task automatic fill_random(input int n, input int gap_max);
    for (int k = 0; k < n; k++) begin
      int gaps;
      gaps = $urandom_range(0, gap_max);
      for (int g = 0; g < gaps; g++)
        cyc(0, 0, 16'($urandom()), 1'($urandom()), 5'($urandom()));
      cyc(0, 1, 16'($urandom()), 1'($urandom()), 5'($urandom()));
    end
  endtask

  task automatic stop_if_wrap();
`ifdef LOGGER_WRAP_EN
    cyc(1, 0, 16'h0, 0, 5'd0);
`endif
  endtask

  initial begin
    // Reset held for 3 clocks
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_all();
    i_reset = 1'b1;
    cyc(0, 0, 16'h0, 1, 5'd0);
    chk("t1_rd_valid", 32'(o_rd_valid), 32'd1);
    chk("t1_rd_data", 32'(o_rd_data), 32'd0);

    // Sequential fill and back-to-back readback
    cyc(1, 0, 16'h0, 0, 5'd0);
    for (int k = 0; k < 32; k++) cyc(0, 1, 16'(k), 0, 5'd0);
    chk("t2_full", 32'(o_full), 32'd1);
    chk("t2_count", 32'(o_count), 32'd32);
    stop_if_wrap();
    for (int k = 0; k < 32; k++) begin
      cyc(0, 0, 16'h0, 1, 5'(k));
      chk("t2_readback", 32'(o_rd_data), 32'(k));
    end

    // Read colliding with re-arm returns pre-clear data
    cyc(1, 0, 16'h0, 1, 5'd5);
    chk("t3_read_preclear", 32'(o_rd_data), 32'h5);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 16'(16'hA001 + k), 0, 5'd0);
      cyc(0, 0, 16'h0, 1, 5'($urandom()));
      cyc(0, 0, 16'h0, 1, 5'($urandom()));
    end
    chk("t3_count", 32'(o_count), 32'd5);
    chk("t3_busy", 32'(o_busy), 32'd1);
    chk("t3_rd_ignored", 32'(o_rd_valid), 32'd0);
    fill_random(27, 2);
    stop_if_wrap();
    cyc(0, 0, 16'h0, 1, 5'd2);
    chk("t3_word2", 32'(o_rd_data), 32'hA003);
    for (int k = 0; k < 8; k++) cyc(0, 0, 16'h0, 1, 5'($urandom()));

    // i_run with i_valid: colliding word dropped
    cyc(1, 1, 16'hBEEF, 0, 5'd0);
    cyc(0, 1, 16'h1234, 0, 5'd0);
    chk("t4_count", 32'(o_count), 32'd1);
    fill_random(31, 1);
    stop_if_wrap();
    cyc(0, 0, 16'h0, 1, 5'd0);
    chk("t4_mem0", 32'(o_rd_data), 32'h1234);

    // Reset in the middle of a capture
    cyc(1, 0, 16'h0, 0, 5'd0);
    for (int k = 0; k < 10; k++) cyc(0, 1, 16'($urandom()), 0, 5'd0);
    #2;
    i_reset = 1'b0;
    #1;
    chk("t5_busy_async", 32'(o_busy), 32'd0);
    chk("t5_count_async", 32'(o_count), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    check_all();
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 16'h0, 1, 5'(k));
      chk("t5_old_hidden", 32'(o_rd_data), 32'd0);
    end
    cyc(1, 0, 16'h0, 0, 5'd0);
    fill_random(32, 2);
    stop_if_wrap();
    for (int k = 0; k < 32; k++) cyc(0, 0, 16'h0, 1, 5'(k));

`ifdef LOGGER_WRAP_EN
    // Circular capture: 40 words then stop
    cyc(1, 0, 16'h0, 0, 5'd0);
    for (int k = 0; k < 40; k++) cyc(0, 1, 16'(k), 0, 5'd0);
    cyc(1, 0, 16'h0, 0, 5'd0);
    chk("t6_full", 32'(o_full), 32'd1);
    chk("t6_busy", 32'(o_busy), 32'd0);
    cyc(0, 0, 16'h0, 1, 5'd0);
    chk("t6_oldest", 32'(o_rd_data), 32'd8);
    cyc(0, 0, 16'h0, 1, 5'd31);
    chk("t6_newest", 32'(o_rd_data), 32'd39);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
